bp_fifo_to_axi_master: RTL and testbench
========================================

# bp_fifo_to_axi_master

Single-outstanding-transaction AXI4 master that turns a simple valid/ready FIFO request stream into single-beat AXI4 read (AR/R) or write (AW/W/B) transactions, and returns one response per request on a valid/yumi FIFO. It is the initiator-side counterpart of the FIFO-to-AXI responder used by the test bootrom. It lets FSM-style clients, such as loaders and debug or test drivers, reach any AXI slave without needing burst logic.

## Interface
- m_axi_addr_width_p, 64, AXI address width.
- m_axi_data_width_p, 64, AXI data width; one beat per transaction.
- m_axi_id_width_p, 4, AXI ID width.
- axi_id_p, 0, constant value driven on awid/arid.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  reset, synchronous, active-high.
- v_i  in  1  request valid.
- ready_and_o  out  1  request ready; a request transfers on v_i & ready_and_o.
- w_i  in  1  1 = write, 0 = read.
- addr_i  in  m_axi_addr_width_p  byte address.
- data_i  in  m_axi_data_width_p  lane-aligned write data.
- wmask_i  in  m_axi_data_width_p/8  byte strobes.
- size_i  in  3  AXI size encoding, log2 of bytes.
- v_o  out  1  response valid.
- yumi_i  in  1  response consumed; legal only while v_o=1.
- w_o  out  1  response is a write acknowledgement.
- data_o  out  m_axi_data_width_p  raw read beat; 0 for writes.
- err_o  out  1  AXI resp was not OKAY.
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*: full AXI4 master port set with standard widths (awaddr/awvalid/awready/awid/awlock/awcache/awprot/awlen/awsize/awburst/awqos/awregion, wdata/wvalid/wready/wlast/wstrb, bvalid/bready/bid/bresp, and the matching ar* and r* signals).

## Operation
- Request capture: on v_i & ready_and_o, the block registers addr, data, wmask, size and w.
- FSM states: e_ready, e_read_addr, e_read_data, e_write, e_write_resp, e_resp.
- e_ready:
  - ready_and_o=1.
  - On accept, go to e_write if w_i, otherwise e_read_addr.
- e_read_addr:
  - arvalid=1.
  - On arready, go to e_read_data.
- e_read_data:
  - rready=1.
  - On rvalid, capture rdata into data_o and capture err = (rresp != 2'b00).
  - Then go to e_resp.
- e_write:
  - awvalid=~aw_done and wvalid=~w_done.
  - aw_done sets on an AW handshake; w_done sets on a W handshake.
  - Handshakes may land in the same cycle or in either order.
  - When both are done, or both complete this cycle, go to e_write_resp and clear both flags.
- e_write_resp:
  - bready=1.
  - On bvalid, capture err = (bresp != 2'b00), set data_o=0, set w_o=1.
  - Then go to e_resp.
- e_resp:
  - v_o=1.
  - On yumi_i, go to e_ready.
  - ready_and_o stays 0 until the FSM is back in e_ready, so there is no request/response overlap.
- Constant tie-offs:
  - awlen=arlen=0, wlast=1, awburst=arburst=2'b01 (INCR).
  - awcache=arcache=4'b0011, awprot=arprot=0, awlock=arlock=0, qos=0, region=0.
  - awid=arid=axi_id_p.
  - awsize/arsize = captured size.
- AXI payload: awaddr/araddr = captured addr; wdata/wstrb = captured data/wmask, with no lane shifting or replication.
- Ignored inputs: rid, bid and rlast are ignored. A response with rlast=0 is still accepted as the single beat.

## Timing
- Reset values: state=e_ready; all AXI valid/ready outputs 0; v_o=0, err_o=0, w_o=0, data_o=0; aw_done=w_done=0.
- ready_and_o=1 in the first cycle after reset deasserts.
- Read latency: request accepted at cycle 0, arvalid at cycle 1, rready at cycle 2 at the earliest, v_o one cycle after the R handshake. Minimum accept-to-v_o is 3 cycles.
- Write latency: awvalid and wvalid both assert at cycle 1. bready asserts the cycle after the last of AW/W completes. v_o asserts one cycle after the B handshake. Minimum accept-to-v_o is 3 cycles.
- AXI valid holding: every valid stays asserted, with stable payload, until its handshake. Valids never depend combinationally on the matching ready.
- ready_and_o and v_o are functions of state only. v_o never depends on yumi_i.
- Back-to-back: yumi_i in e_resp gives ready_and_o=1 in the next cycle. Steady-state throughput is one transaction per 4 cycles at best.
- Reset mid-transaction: the FSM returns to e_ready and all valids drop. The system must reset the slave at the same time.
- Non-OKAY responses (SLVERR/DECERR): the transaction still completes normally and err_o=1 is held with v_o.

## Test plan
- Read with zero-wait slave: request addr=0x1008, size=3. Slave returns rdata=0xDEADBEEF_CAFEF00D with OKAY. Expect arvalid at cycle 1, v_o at cycle 3, data_o=0xDEADBEEF_CAFEF00D, w_o=0, err_o=0.
- Write with AW/W skew: request addr=0x40, data=0x11223344_55667788, wmask=0xF0. Slave takes W at cycle 1 and AW at cycle 4. Expect wvalid to drop after cycle 1 and awvalid to hold until cycle 4, then bready at cycle 5, v_o=1 and w_o=1 after B.
- Backpressure: hold arready=0 for 5 cycles, then rvalid=0 for 3 cycles, then hold yumi_i=0 for 4 cycles. Expect araddr stable throughout, v_o held, ready_and_o=0 throughout, and exactly one AR and one R handshake.
- Error response: write that receives bresp=2'b10, then read that receives rresp=2'b11. Expect err_o=1 on both responses and the FSM returning to e_ready both times.
- Back-to-back mixed traffic: 100 random reads and writes against a memory model, with random ready/valid stalls. Expect read data to match the model and exactly one AXI transaction per request.
- Reset mid-transaction: assert reset while in e_write with aw_done=1. Expect all valids 0 the next cycle and ready_and_o=1 after reset releases.

Source files
------------

// File: rtl/bp_fifo_to_axi_master.sv
// rtl/bp_fifo_to_axi_master.sv - single-outstanding AXI4 master bridging a valid/ready request FIFO
// One request becomes one single-beat AR/R or AW/W/B transaction; one response per request.
module bp_fifo_to_axi_master #(
    parameter int m_axi_addr_width_p = 64,
    parameter int m_axi_data_width_p = 64,
    parameter int m_axi_id_width_p   = 4,
    parameter int axi_id_p           = 0
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic                            v_i,
    output logic                            ready_and_o,
    input  logic                            w_i,
    input  logic [m_axi_addr_width_p-1:0]   addr_i,
    input  logic [m_axi_data_width_p-1:0]   data_i,
    input  logic [m_axi_data_width_p/8-1:0] wmask_i,
    input  logic [2:0]                      size_i,

    output logic                            v_o,
    input  logic                            yumi_i,
    output logic                            w_o,
    output logic [m_axi_data_width_p-1:0]   data_o,
    output logic                            err_o,

    output logic [m_axi_addr_width_p-1:0]   m_axi_awaddr_o,
    output logic                            m_axi_awvalid_o,
    input  logic                            m_axi_awready_i,
    output logic [m_axi_id_width_p-1:0]     m_axi_awid_o,
    output logic                            m_axi_awlock_o,
    output logic [3:0]                      m_axi_awcache_o,
    output logic [2:0]                      m_axi_awprot_o,
    output logic [7:0]                      m_axi_awlen_o,
    output logic [2:0]                      m_axi_awsize_o,
    output logic [1:0]                      m_axi_awburst_o,
    output logic [3:0]                      m_axi_awqos_o,
    output logic [3:0]                      m_axi_awregion_o,

    output logic [m_axi_data_width_p-1:0]   m_axi_wdata_o,
    output logic                            m_axi_wvalid_o,
    input  logic                            m_axi_wready_i,
    output logic                            m_axi_wlast_o,
    output logic [m_axi_data_width_p/8-1:0] m_axi_wstrb_o,

    input  logic                            m_axi_bvalid_i,
    output logic                            m_axi_bready_o,
    input  logic [m_axi_id_width_p-1:0]     m_axi_bid_i,
    input  logic [1:0]                      m_axi_bresp_i,

    output logic [m_axi_addr_width_p-1:0]   m_axi_araddr_o,
    output logic                            m_axi_arvalid_o,
    input  logic                            m_axi_arready_i,
    output logic [m_axi_id_width_p-1:0]     m_axi_arid_o,
    output logic                            m_axi_arlock_o,
    output logic [3:0]                      m_axi_arcache_o,
    output logic [2:0]                      m_axi_arprot_o,
    output logic [7:0]                      m_axi_arlen_o,
    output logic [2:0]                      m_axi_arsize_o,
    output logic [1:0]                      m_axi_arburst_o,
    output logic [3:0]                      m_axi_arqos_o,
    output logic [3:0]                      m_axi_arregion_o,

    input  logic [m_axi_data_width_p-1:0]   m_axi_rdata_i,
    input  logic                            m_axi_rvalid_i,
    output logic                            m_axi_rready_o,
    input  logic [m_axi_id_width_p-1:0]     m_axi_rid_i,
    input  logic                            m_axi_rlast_i,
    input  logic [1:0]                      m_axi_rresp_i
);

    localparam int mask_width_lp = m_axi_data_width_p / 8;

    typedef enum logic [2:0] {
        e_ready,
        e_read_addr,
        e_read_data,
        e_write,
        e_write_resp,
        e_resp
    } state_e;

    state_e                          state_q, state_d;
    logic [m_axi_addr_width_p-1:0]   addr_q, addr_d;
    logic [m_axi_data_width_p-1:0]   wdata_q, wdata_d;
    logic [mask_width_lp-1:0]        wmask_q, wmask_d;
    logic [2:0]                      size_q, size_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic [m_axi_data_width_p-1:0]   resp_data_q, resp_data_d;
    logic                            resp_err_q, resp_err_d;
    logic                            resp_w_q, resp_w_d;
    logic                            aw_fin, w_fin;

    // Handshake and response strobes depend only on state so no valid waits on its ready.
    assign ready_and_o     = (state_q == e_ready);
    assign v_o             = (state_q == e_resp);
    assign m_axi_arvalid_o = (state_q == e_read_addr);
    assign m_axi_rready_o  = (state_q == e_read_data);
    assign m_axi_awvalid_o = (state_q == e_write) & ~aw_done_q;
    assign m_axi_wvalid_o  = (state_q == e_write) & ~w_done_q;
    assign m_axi_bready_o  = (state_q == e_write_resp);

    assign w_o    = resp_w_q;
    assign data_o = resp_data_q;
    assign err_o  = resp_err_q;

    assign m_axi_awaddr_o   = addr_q;
    assign m_axi_awid_o     = m_axi_id_width_p'(axi_id_p);
    assign m_axi_awlock_o   = 1'b0;
    assign m_axi_awcache_o  = 4'b0011;
    assign m_axi_awprot_o   = 3'b000;
    assign m_axi_awlen_o    = 8'd0;
    assign m_axi_awsize_o   = size_q;
    assign m_axi_awburst_o  = 2'b01;
    assign m_axi_awqos_o    = 4'd0;
    assign m_axi_awregion_o = 4'd0;

    assign m_axi_wdata_o = wdata_q;
    assign m_axi_wstrb_o = wmask_q;
    assign m_axi_wlast_o = 1'b1;

    assign m_axi_araddr_o   = addr_q;
    assign m_axi_arid_o     = m_axi_id_width_p'(axi_id_p);
    assign m_axi_arlock_o   = 1'b0;
    assign m_axi_arcache_o  = 4'b0011;
    assign m_axi_arprot_o   = 3'b000;
    assign m_axi_arlen_o    = 8'd0;
    assign m_axi_arsize_o   = size_q;
    assign m_axi_arburst_o  = 2'b01;
    assign m_axi_arqos_o    = 4'd0;
    assign m_axi_arregion_o = 4'd0;

    // IDs and rlast carry no information for a single-beat, single-outstanding master.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_bid_i, m_axi_rid_i, m_axi_rlast_i};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        size_d      = size_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        resp_w_d    = resp_w_q;
        aw_fin      = aw_done_q | (m_axi_awvalid_o & m_axi_awready_i);
        w_fin       = w_done_q | (m_axi_wvalid_o & m_axi_wready_i);

        unique case (state_q)
            e_ready: begin
                if (v_i) begin
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    wmask_d = wmask_i;
                    size_d  = size_i;
                    state_d = w_i ? e_write : e_read_addr;
                end
            end
            e_read_addr: begin
                if (m_axi_arready_i) begin
                    state_d = e_read_data;
                end
            end
            e_read_data: begin
                if (m_axi_rvalid_i) begin
                    resp_data_d = m_axi_rdata_i;
                    resp_err_d  = (m_axi_rresp_i != 2'b00);
                    resp_w_d    = 1'b0;
                    state_d     = e_resp;
                end
            end
            e_write: begin
                // AW and W complete independently; move on once both have landed.
                if (aw_fin & w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = e_write_resp;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            e_write_resp: begin
                if (m_axi_bvalid_i) begin
                    resp_data_d = '0;
                    resp_err_d  = (m_axi_bresp_i != 2'b00);
                    resp_w_d    = 1'b1;
                    state_d     = e_resp;
                end
            end
            e_resp: begin
                if (yumi_i) begin
                    state_d = e_ready;
                end
            end
            default: begin
                state_d = e_ready;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= e_ready;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            size_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            resp_w_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            size_q      <= size_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            resp_w_q    <= resp_w_d;
        end
    end

endmodule

// File: tb/tb_bp_fifo_to_axi_master.sv
// tb/tb_bp_fifo_to_axi_master.sv - self-checking bench for bp_fifo_to_axi_master
// Cycle-driven AXI slave with per-channel stalls, directed vector table and random traffic against a memory model.
module tb_bp_fifo_to_axi_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_i, ready_and_o, w_i;
    logic [63:0] addr_i, data_i;
    logic [7:0]  wmask_i;
    logic [2:0]  size_i;
    logic        v_o, yumi_i, w_o, err_o;
    logic [63:0] data_o;

    logic [63:0] m_axi_awaddr_o;
    logic        m_axi_awvalid_o, m_axi_awready_i, m_axi_awlock_o;
    logic [3:0]  m_axi_awid_o, m_axi_awcache_o, m_axi_awqos_o, m_axi_awregion_o;
    logic [2:0]  m_axi_awprot_o, m_axi_awsize_o;
    logic [7:0]  m_axi_awlen_o;
    logic [1:0]  m_axi_awburst_o;
    logic [63:0] m_axi_wdata_o;
    logic        m_axi_wvalid_o, m_axi_wready_i, m_axi_wlast_o;
    logic [7:0]  m_axi_wstrb_o;
    logic        m_axi_bvalid_i, m_axi_bready_o;
    logic [3:0]  m_axi_bid_i;
    logic [1:0]  m_axi_bresp_i;
    logic [63:0] m_axi_araddr_o;
    logic        m_axi_arvalid_o, m_axi_arready_i, m_axi_arlock_o;
    logic [3:0]  m_axi_arid_o, m_axi_arcache_o, m_axi_arqos_o, m_axi_arregion_o;
    logic [2:0]  m_axi_arprot_o, m_axi_arsize_o;
    logic [7:0]  m_axi_arlen_o;
    logic [1:0]  m_axi_arburst_o;
    logic [63:0] m_axi_rdata_i;
    logic        m_axi_rvalid_i, m_axi_rready_o, m_axi_rlast_i;
    logic [3:0]  m_axi_rid_i;
    logic [1:0]  m_axi_rresp_i;

    bp_fifo_to_axi_master dut (
        .clk(clk), .reset(reset),
        .v_i(v_i), .ready_and_o(ready_and_o), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .wmask_i(wmask_i), .size_i(size_i),
        .v_o(v_o), .yumi_i(yumi_i), .w_o(w_o), .data_o(data_o), .err_o(err_o),
        .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awvalid_o(m_axi_awvalid_o),
        .m_axi_awready_i(m_axi_awready_i), .m_axi_awid_o(m_axi_awid_o),
        .m_axi_awlock_o(m_axi_awlock_o), .m_axi_awcache_o(m_axi_awcache_o),
        .m_axi_awprot_o(m_axi_awprot_o), .m_axi_awlen_o(m_axi_awlen_o),
        .m_axi_awsize_o(m_axi_awsize_o), .m_axi_awburst_o(m_axi_awburst_o),
        .m_axi_awqos_o(m_axi_awqos_o), .m_axi_awregion_o(m_axi_awregion_o),
        .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wvalid_o(m_axi_wvalid_o),
        .m_axi_wready_i(m_axi_wready_i), .m_axi_wlast_o(m_axi_wlast_o),
        .m_axi_wstrb_o(m_axi_wstrb_o),
        .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o),
        .m_axi_bid_i(m_axi_bid_i), .m_axi_bresp_i(m_axi_bresp_i),
        .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arvalid_o(m_axi_arvalid_o),
        .m_axi_arready_i(m_axi_arready_i), .m_axi_arid_o(m_axi_arid_o),
        .m_axi_arlock_o(m_axi_arlock_o), .m_axi_arcache_o(m_axi_arcache_o),
        .m_axi_arprot_o(m_axi_arprot_o), .m_axi_arlen_o(m_axi_arlen_o),
        .m_axi_arsize_o(m_axi_arsize_o), .m_axi_arburst_o(m_axi_arburst_o),
        .m_axi_arqos_o(m_axi_arqos_o), .m_axi_arregion_o(m_axi_arregion_o),
        .m_axi_rdata_i(m_axi_rdata_i), .m_axi_rvalid_i(m_axi_rvalid_i),
        .m_axi_rready_o(m_axi_rready_o), .m_axi_rid_i(m_axi_rid_i),
        .m_axi_rlast_i(m_axi_rlast_i), .m_axi_rresp_i(m_axi_rresp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [2:0]  size;
        int          ar_st, r_st, aw_st, w_st, b_st, y_st;
        logic [1:0]  resp;
        logic [63:0] rdata;
    } txn_t;

    typedef struct {
        txn_t        t;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [63:0] slave_mem [int];
    logic [63:0] ref_mem [int];

    int          r_lat, r_bad, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [63:0] r_data;
    logic        r_err, r_w, r_ready_after, r_timeout;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic [63:0] addr, input logic [63:0] data,
                                input logic [7:0] mask, input logic [2:0] size,
                                input int ar_st, input int r_st, input int aw_st, input int w_st,
                                input int b_st, input int y_st, input logic [1:0] resp,
                                input logic [63:0] rdata);
        txn_t t;
        t.w = w; t.addr = addr; t.data = data; t.mask = mask; t.size = size;
        t.ar_st = ar_st; t.r_st = r_st; t.aw_st = aw_st; t.w_st = w_st;
        t.b_st = b_st; t.y_st = y_st; t.resp = resp; t.rdata = rdata;
        return t;
    endfunction

    function automatic logic [63:0] init_word(input int k);
        return {32'hC0DE_0000 + 32'(k), 32'h0BAD_0000 + 32'(k)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] mask);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (mask[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] slave_get(input int k);
        return slave_mem.exists(k) ? slave_mem[k] : init_word(k);
    endfunction

    function automatic logic [63:0] ref_get(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after yumi_i was taken.
    task automatic run_txn(input txn_t t, input bit use_mem);
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, y_cnt, n;
        bit ar_pend, aw_pend, w_pend, got_v, yumi_sent, finished;
        logic [63:0] ar_seen, aw_seen, wd_seen;
        logic [7:0]  ws_seen;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; y_cnt = 0;
        ar_pend = 0; aw_pend = 0; w_pend = 0; got_v = 0; yumi_sent = 0; finished = 0;
        ar_seen = '0; aw_seen = '0; wd_seen = '0; ws_seen = '0;
        r_lat = -1; r_bad = 0; ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        r_data = 'x; r_err = 1'bx; r_w = 1'bx; r_ready_after = 1'b0; r_timeout = 1'b0;

        v_i = 1'b1; w_i = t.w; addr_i = t.addr; data_i = t.data; wmask_i = t.mask; size_i = t.size;
        n = 0;
        while (!ready_and_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready_and_o) r_timeout = 1'b1;
        @(negedge clk);
        v_i = 1'b0; w_i = 1'($urandom); addr_i = {$urandom, $urandom};
        data_i = {$urandom, $urandom}; wmask_i = 8'($urandom); size_i = 3'($urandom);

        for (int c = 1; c <= 300; c++) begin
            if (yumi_sent) begin
                r_ready_after = ready_and_o;
                finished = 1;
                break;
            end
            if (ready_and_o) r_bad++;

            if (ar_pend && !m_axi_arvalid_o) r_bad++;
            if (m_axi_arvalid_o) begin
                if (ar_hs > 0 || m_axi_araddr_o != t.addr || m_axi_arsize_o != t.size ||
                    m_axi_arlen_o != 0 || m_axi_arburst_o != 2'b01 || m_axi_arcache_o != 4'b0011 ||
                    m_axi_arprot_o != 0 || m_axi_arlock_o != 0 || m_axi_arqos_o != 0 ||
                    m_axi_arregion_o != 0 || m_axi_arid_o != 0) r_bad++;
                m_axi_arready_i = (ar_cnt == t.ar_st);
                ar_cnt++;
                if (m_axi_arready_i) begin
                    ar_hs++;
                    ar_seen = m_axi_araddr_o;
                end
            end else begin
                m_axi_arready_i = 1'($urandom_range(0, 1));
            end
            ar_pend = m_axi_arvalid_o && !m_axi_arready_i;

            if (m_axi_rready_o) begin
                if (ar_hs == 0 || r_hs > 0) r_bad++;
                m_axi_rvalid_i = (r_cnt == t.r_st);
                r_cnt++;
                m_axi_rdata_i = use_mem ? slave_get(int'(ar_seen[31:3])) : t.rdata;
                m_axi_rresp_i = t.resp;
                m_axi_rlast_i = 1'($urandom);
                m_axi_rid_i = 4'($urandom);
                if (m_axi_rvalid_i) r_hs++;
            end else begin
                m_axi_rvalid_i = 1'b0;
            end

            if (aw_pend && !m_axi_awvalid_o) r_bad++;
            if (m_axi_awvalid_o) begin
                if (aw_hs > 0 || m_axi_awaddr_o != t.addr || m_axi_awsize_o != t.size ||
                    m_axi_awlen_o != 0 || m_axi_awburst_o != 2'b01 || m_axi_awcache_o != 4'b0011 ||
                    m_axi_awprot_o != 0 || m_axi_awlock_o != 0 || m_axi_awqos_o != 0 ||
                    m_axi_awregion_o != 0 || m_axi_awid_o != 0) r_bad++;
                m_axi_awready_i = (aw_cnt == t.aw_st);
                aw_cnt++;
                if (m_axi_awready_i) begin
                    aw_hs++;
                    aw_seen = m_axi_awaddr_o;
                end
            end else begin
                m_axi_awready_i = 1'($urandom_range(0, 1));
            end
            aw_pend = m_axi_awvalid_o && !m_axi_awready_i;

            if (w_pend && !m_axi_wvalid_o) r_bad++;
            if (m_axi_wvalid_o) begin
                if (w_hs > 0 || m_axi_wdata_o != t.data || m_axi_wstrb_o != t.mask ||
                    m_axi_wlast_o != 1'b1) r_bad++;
                m_axi_wready_i = (w_cnt == t.w_st);
                w_cnt++;
                if (m_axi_wready_i) begin
                    w_hs++;
                    wd_seen = m_axi_wdata_o;
                    ws_seen = m_axi_wstrb_o;
                end
            end else begin
                m_axi_wready_i = 1'($urandom_range(0, 1));
            end
            w_pend = m_axi_wvalid_o && !m_axi_wready_i;

            if (m_axi_bready_o) begin
                if (aw_hs != 1 || w_hs != 1 || b_hs > 0) r_bad++;
                m_axi_bvalid_i = (b_cnt == t.b_st);
                b_cnt++;
                m_axi_bresp_i = t.resp;
                m_axi_bid_i = 4'($urandom);
                if (m_axi_bvalid_i) begin
                    b_hs++;
                    if (use_mem)
                        slave_mem[int'(aw_seen[31:3])] =
                            merge(slave_get(int'(aw_seen[31:3])), wd_seen, ws_seen);
                end
            end else begin
                m_axi_bvalid_i = 1'b0;
            end

            if (v_o) begin
                if (!got_v) begin
                    got_v = 1; r_lat = c; r_data = data_o; r_err = err_o; r_w = w_o;
                end else if (data_o !== r_data || err_o !== r_err || w_o !== r_w) begin
                    r_bad++;
                end
                yumi_i = (y_cnt == t.y_st);
                y_cnt++;
                if (yumi_i) yumi_sent = 1;
            end else begin
                yumi_i = 1'b0;
                if (got_v) r_bad++;
            end
            @(negedge clk);
        end
        if (!finished) r_timeout = 1'b1;
        yumi_i = 0; m_axi_arready_i = 0; m_axi_awready_i = 0; m_axi_wready_i = 0;
        m_axi_rvalid_i = 0; m_axi_bvalid_i = 0;
    endtask

    task automatic check_txn(input string nm, input txn_t t, input logic [63:0] exp_data,
                             input logic exp_err, input int exp_lat);
        logic [19:0] hs;
        hs = {ar_hs[3:0], r_hs[3:0], aw_hs[3:0], w_hs[3:0], b_hs[3:0]};
        chk({nm, "_timeout"}, r_timeout, 1'b0);
        chk({nm, "_latency"}, 64'(r_lat), 64'(exp_lat));
        chk({nm, "_data"}, r_data, exp_data);
        chk({nm, "_err"}, r_err, exp_err);
        chk({nm, "_w"}, r_w, t.w);
        chk({nm, "_handshakes"}, hs, t.w ? 20'h00111 : 20'h11000);
        chk({nm, "_protocol_errs"}, 64'(r_bad), 64'd0);
        chk({nm, "_ready_after"}, r_ready_after, 1'b1);
    endtask

    function automatic int model_lat(input txn_t t);
        if (t.w) return 3 + ((t.aw_st > t.w_st) ? t.aw_st : t.w_st) + t.b_st;
        return 3 + t.ar_st + t.r_st;
    endfunction

    vec_t vecs[8];

    initial begin
        txn_t t;
        logic [63:0] exp_d;
        int k;

        vecs[0].t = mk(0, 64'h1008, 64'h0, 8'h00, 3, 0, 0, 0, 0, 0, 0, 2'b00, 64'hDEADBEEF_CAFEF00D);
        vecs[0].exp_data = 64'hDEADBEEF_CAFEF00D; vecs[0].exp_err = 0; vecs[0].exp_lat = 3;
        vecs[1].t = mk(1, 64'h40, 64'h11223344_55667788, 8'hF0, 3, 0, 0, 3, 0, 0, 0, 2'b00, 64'h0);
        vecs[1].exp_data = 64'h0; vecs[1].exp_err = 0; vecs[1].exp_lat = 6;
        vecs[2].t = mk(0, 64'h2000, 64'h0, 8'h00, 3, 5, 3, 0, 0, 0, 4, 2'b00, 64'h01234567_89ABCDEF);
        vecs[2].exp_data = 64'h01234567_89ABCDEF; vecs[2].exp_err = 0; vecs[2].exp_lat = 11;
        vecs[3].t = mk(1, 64'h80, 64'hAAAA5555_0F0F0F0F, 8'hFF, 3, 0, 0, 0, 0, 0, 1, 2'b10, 64'h0);
        vecs[3].exp_data = 64'h0; vecs[3].exp_err = 1; vecs[3].exp_lat = 3;
        vecs[4].t = mk(0, 64'h88, 64'h0, 8'h00, 3, 0, 0, 0, 0, 0, 0, 2'b11, 64'hFFFF0000_FFFF0000);
        vecs[4].exp_data = 64'hFFFF0000_FFFF0000; vecs[4].exp_err = 1; vecs[4].exp_lat = 3;
        vecs[5].t = mk(1, 64'h100, 64'h0102030405060708, 8'h0F, 2, 0, 0, 0, 2, 1, 0, 2'b00, 64'h0);
        vecs[5].exp_data = 64'h0; vecs[5].exp_err = 0; vecs[5].exp_lat = 6;
        vecs[6].t = mk(1, 64'h108, 64'h8877665544332211, 8'h3C, 1, 0, 0, 2, 2, 0, 2, 2'b00, 64'h0);
        vecs[6].exp_data = 64'h0; vecs[6].exp_err = 0; vecs[6].exp_lat = 5;
        vecs[7].t = mk(0, 64'h1004, 64'h0, 8'h00, 2, 1, 0, 0, 0, 0, 0, 2'b00, 64'h5A5A5A5A_A5A5A5A5);
        vecs[7].exp_data = 64'h5A5A5A5A_A5A5A5A5; vecs[7].exp_err = 0; vecs[7].exp_lat = 4;

        reset = 1; v_i = 0; w_i = 0; addr_i = 0; data_i = 0; wmask_i = 0; size_i = 0; yumi_i = 0;
        m_axi_awready_i = 0; m_axi_wready_i = 0; m_axi_bvalid_i = 0; m_axi_bid_i = 0;
        m_axi_bresp_i = 0; m_axi_arready_i = 0; m_axi_rdata_i = 0; m_axi_rvalid_i = 0;
        m_axi_rid_i = 0; m_axi_rlast_i = 0; m_axi_rresp_i = 0;
        repeat (3) @(negedge clk);
        chk("reset_valids", {m_axi_awvalid_o, m_axi_wvalid_o, m_axi_arvalid_o,
                             m_axi_rready_o, m_axi_bready_o, v_o}, 6'b0);
        chk("reset_resp", {data_o, err_o, w_o}, 66'b0);
        reset = 0;
        @(negedge clk);
        chk("ready_after_reset", ready_and_o, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].t, 0);
            check_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].exp_data,
                      vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Reset while in e_write with AW already accepted and W still pending.
        v_i = 1; w_i = 1; addr_i = 64'h300; data_i = 64'h1; wmask_i = 8'hFF; size_i = 3;
        @(negedge clk);
        v_i = 0;
        chk("rst_c1_awvalid", m_axi_awvalid_o, 1'b1);
        chk("rst_c1_wvalid", m_axi_wvalid_o, 1'b1);
        m_axi_awready_i = 1; m_axi_wready_i = 0;
        @(negedge clk);
        m_axi_awready_i = 0;
        chk("rst_c2_awvalid", m_axi_awvalid_o, 1'b0);
        chk("rst_c2_wvalid", m_axi_wvalid_o, 1'b1);
        reset = 1;
        @(negedge clk);
        chk("rst_valids", {m_axi_awvalid_o, m_axi_wvalid_o, m_axi_arvalid_o,
                           m_axi_rready_o, m_axi_bready_o, v_o}, 6'b0);
        reset = 0;
        @(negedge clk);
        chk("rst_ready", ready_and_o, 1'b1);
        t = mk(1, 64'h308, 64'hCAFE, 8'h03, 3, 0, 0, 1, 0, 0, 0, 2'b00, 64'h0);
        run_txn(t, 0);
        check_txn("post_rst", t, 64'h0, 1'b0, model_lat(t));

        for (int i = 0; i < 100; i++) begin
            k = 32'h400 + $urandom_range(0, 7);
            t = mk(1'($urandom), 64'(k) << 3, {$urandom, $urandom}, 8'($urandom),
                   3'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00, 64'h0);
            if (t.w) begin
                exp_d = 64'h0;
                ref_mem[k] = merge(ref_get(k), t.data, t.mask);
            end else begin
                exp_d = ref_get(k);
            end
            run_txn(t, 1);
            check_txn($sformatf("rnd%0d", i), t, exp_d, t.resp != 2'b00, model_lat(t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
